gvp_store_push: RTL
===================

GVP_STORE_PUSH -- requirements
Module: gvp_store_push

Interface
REQ-001 SHALL have parameter NUM_SRCS, default 8: number of 32-bit data source channels.
REQ-002 SHALL have parameter SRC_MASK_LSB, default 8: LSB position of the NUM_SRCS-bit source-select mask within options.
REQ-003 SHALL have port a_clk  in  1: single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port a_resetn  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port store_data  in  2: one-cycle request strobe; 2 = header event, 1 = data event, 0/3 = none.
REQ-006 SHALL have port options  in  32: section options; bits [SRC_MASK_LSB+NUM_SRCS-1:SRC_MASK_LSB] are the source mask.
REQ-007 SHALL have ports pos_x, pos_y, pos_z, pos_u  in  32 each: current vector position.
REQ-008 SHALL have port src_data  in  32*NUM_SRCS: source channels, channel k at bits [32k+31:32k].
REQ-009 SHALL have ports M_AXIS_tdata out 32, M_AXIS_tvalid out 1, M_AXIS_tready in 1, M_AXIS_tlast out 1: packet stream.
REQ-010 SHALL have port busy  out  1: high while a packet is in flight or one is pending.
REQ-011 SHALL have port overflow_cnt  out  16: count of dropped events, saturating at 0xFFFF.

Function
REQ-012 SHALL capture options, pos_*, src_data and event type into a snapshot in the same cycle a valid event is sampled.
REQ-013 SHALL implement FSM IDLE -> MARK -> BODY -> IDLE; MARK emits the marker word, BODY emits the payload words.
REQ-014 SHALL assert M_AXIS_tvalid with the marker word in the cycle after the event is sampled in IDLE (latency 1).
REQ-015 SHALL format the marker as {8'hA5 header / 8'h5A data, 8-bit payload word count, 16-bit sequence number}.
REQ-016 SHALL emit a header payload of options, pos_x, pos_y, pos_z, pos_u (5 words), in that order.
REQ-017 SHALL emit as the data payload the snapshot src channels whose mask bit is set, in ascending channel index.
REQ-018 SHALL emit a data packet whose mask is zero as the marker alone, count 0, with tlast set on the marker.
REQ-019 SHALL assert M_AXIS_tlast only on the final word of each packet.
REQ-020 SHALL advance words only on tvalid&&tready; tdata/tlast SHALL be held stable while tvalid&&!tready.
REQ-021 SHALL increment the 16-bit sequence number once per completed packet, wrapping 0xFFFF -> 0.
REQ-022 SHALL hold one pending event (second snapshot) when an event arrives while not IDLE.
REQ-023 SHALL drop an event that arrives while the pending slot is full and increment overflow_cnt.
REQ-024 SHALL start the pending packet's marker in the cycle after the previous tlast handshake, with no tvalid bubble.
REQ-025 SHALL place an event sampled in the same cycle as a tlast handshake with an empty pending slot into the pending slot, giving the same no-bubble behaviour as REQ-024.
REQ-026 SHALL ignore store_data values 0 and 3.

Reset
REQ-027 SHALL, while a_resetn is low, force IDLE, M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0, busy=0, overflow_cnt=0, sequence=0, pending slot empty.
REQ-028 SHALL discard any in-flight or pending packet on reset assertion mid-packet, with no partial completion after release.

Configuration
REQ-029 SHALL, with macro GVP_STORE_TIMESTAMP_EN defined, include a free-running 32-bit a_clk cycle counter, latch it into the snapshot, and insert it as the first payload word of every packet, counted in the marker count.
REQ-030 SHALL, without GVP_STORE_TIMESTAMP_EN, have no timestamp counter and emit packets exactly per REQ-016/017.

Verification
REQ-031 SHALL cover: reset, tready=1, store_data=2 one cycle with options=0x0000_0300 and pos=1,2,3,4 -> words 0xA505_0000, 0x0000_0300, 1, 2, 3, 4; tlast on word 4; tvalid first seen 1 cycle after strobe.
REQ-032 SHALL cover: mask 0x03 (options=0x0000_0300), src0=0x11, src1=0x22, store_data=1 -> 0x5A02_0001, 0x11, 0x22 (tlast), sequence 1 after REQ-031.
REQ-033 SHALL cover: tready toggled every other cycle during a header packet -> identical word sequence, tdata stable during stalls.
REQ-034 SHALL cover: three data events on consecutive cycles with tready=0 -> packets 1 and 2 emitted back-to-back after tready=1, overflow_cnt=1.
REQ-035 SHALL cover: a_resetn pulsed low during the third word of a header packet -> tvalid=0 immediately, next event yields sequence 0.
REQ-036 SHALL cover: with GVP_STORE_TIMESTAMP_EN, a mask-zero data event -> marker count 1 followed by the timestamp word with tlast, timestamp equal to the counter value at the strobe cycle.

Source files
------------

// File: rtl/gvp_store_push.sv
// gvp_store_push: snapshots store events and streams each as a marker+payload packet.
// Define GVP_STORE_TIMESTAMP_EN to prepend a cycle timestamp to every payload.
module gvp_store_push #(
  parameter int NUM_SRCS     = 8,
  parameter int SRC_MASK_LSB = 8
) (
  input  logic                     a_clk,
  input  logic                     a_resetn,
  input  logic [1:0]               store_data,
  input  logic [31:0]              options,
  input  logic [31:0]              pos_x,
  input  logic [31:0]              pos_y,
  input  logic [31:0]              pos_z,
  input  logic [31:0]              pos_u,
  input  logic [32*NUM_SRCS-1:0]   src_data,
  output logic [31:0]              M_AXIS_tdata,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic                     M_AXIS_tlast,
  output logic                     busy,
  output logic [15:0]              overflow_cnt
);

  localparam int SW = 32 * NUM_SRCS;

  typedef enum logic [1:0] {IDLE, MARK, BODY} st_t;

  typedef struct packed {
    logic          hdr;
    logic [31:0]   opts;
    logic [31:0]   px;
    logic [31:0]   py;
    logic [31:0]   pz;
    logic [31:0]   pu;
    logic [SW-1:0] src;
`ifdef GVP_STORE_TIMESTAMP_EN
    logic [31:0]   ts;
`endif
  } snap_t;

  st_t                 state, nxt;
  snap_t               cur, pnd, in_s, ld_s;
  logic                pnd_v;
  logic [NUM_SRCS-1:0] rem;
  logic [7:0]          left;
  logic [2:0]          hidx;
  logic [15:0]         seq;
  logic [15:0]         ovf;
  logic                ev, hs, done, ld_en;
  logic [31:0]         body_w, src_w;
`ifdef GVP_STORE_TIMESTAMP_EN
  logic [31:0]         ts_cnt;
  logic                ts_pend;
`endif

  function automatic logic [7:0] words_of(input snap_t s);
    logic [7:0] n;
    n = '0;
    if (s.hdr) n = 8'd5;
    else
      for (int k = 0; k < NUM_SRCS; k++)
        if (s.opts[SRC_MASK_LSB+k]) n = n + 8'd1;
`ifdef GVP_STORE_TIMESTAMP_EN
    n = n + 8'd1;
`endif
    return n;
  endfunction

  assign ev    = (store_data == 2'b10) || (store_data == 2'b01);
  assign hs    = M_AXIS_tvalid && M_AXIS_tready;
  assign done  = hs && M_AXIS_tlast;
  assign ld_en = ((state == IDLE) && ev) || (done && (pnd_v || ev));
  assign ld_s  = ((state != IDLE) && pnd_v) ? pnd : in_s;
  assign busy  = (state != IDLE) || pnd_v;
  assign overflow_cnt = ovf;

  // Snapshot of the live inputs for an event sampled this cycle.
  always_comb begin
    in_s      = '0;
    in_s.hdr  = (store_data == 2'b10);
    in_s.opts = options;
    in_s.px   = pos_x;
    in_s.py   = pos_y;
    in_s.pz   = pos_z;
    in_s.pu   = pos_u;
    in_s.src  = src_data;
`ifdef GVP_STORE_TIMESTAMP_EN
    in_s.ts   = ts_cnt;
`endif
  end

  // Lowest remaining masked channel supplies the next data word.
  always_comb begin
    src_w = '0;
    for (int k = NUM_SRCS - 1; k >= 0; k--)
      if (rem[k]) src_w = cur.src[32*k +: 32];
  end

  // Current payload word selection.
  always_comb begin
    body_w = src_w;
    if (cur.hdr) begin
      case (hidx)
        3'd0:    body_w = cur.opts;
        3'd1:    body_w = cur.px;
        3'd2:    body_w = cur.py;
        3'd3:    body_w = cur.pz;
        default: body_w = cur.pu;
      endcase
    end
`ifdef GVP_STORE_TIMESTAMP_EN
    if (ts_pend) body_w = cur.ts;
`endif
  end

  // Next state and stream outputs.
  always_comb begin
    nxt           = state;
    M_AXIS_tvalid = 1'b0;
    M_AXIS_tlast  = 1'b0;
    M_AXIS_tdata  = '0;
    unique case (state)
      IDLE: if (ev) nxt = MARK;
      MARK: begin
        M_AXIS_tvalid = 1'b1;
        M_AXIS_tdata  = {(cur.hdr ? 8'hA5 : 8'h5A), left, seq};
        M_AXIS_tlast  = (left == 8'd0);
      end
      BODY: begin
        M_AXIS_tvalid = 1'b1;
        M_AXIS_tdata  = body_w;
        M_AXIS_tlast  = (left == 8'd1);
      end
      default: nxt = IDLE;
    endcase
    if (M_AXIS_tvalid && M_AXIS_tready) begin
      if (M_AXIS_tlast) nxt = (pnd_v || ev) ? MARK : IDLE;
      else              nxt = BODY;
    end
  end

  // State register.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) state <= IDLE;
    else           state <= nxt;
  end

  // Active/pending snapshots, payload walk, sequence and overflow.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      cur     <= '0;
      pnd     <= '0;
      pnd_v   <= 1'b0;
      rem     <= '0;
      left    <= '0;
      hidx    <= '0;
      seq     <= '0;
      ovf     <= '0;
`ifdef GVP_STORE_TIMESTAMP_EN
      ts_cnt  <= '0;
      ts_pend <= 1'b0;
`endif
    end else begin
`ifdef GVP_STORE_TIMESTAMP_EN
      ts_cnt <= ts_cnt + 32'd1;
`endif
      if (done) seq <= seq + 16'd1;
      if (ld_en) begin
        cur     <= ld_s;
        rem     <= ld_s.opts[SRC_MASK_LSB +: NUM_SRCS];
        left    <= words_of(ld_s);
        hidx    <= '0;
`ifdef GVP_STORE_TIMESTAMP_EN
        ts_pend <= 1'b1;
`endif
      end else if (hs && (state == BODY)) begin
        left <= left - 8'd1;
`ifdef GVP_STORE_TIMESTAMP_EN
        if (ts_pend) ts_pend <= 1'b0;
        else
`endif
        if (cur.hdr) hidx <= hidx + 3'd1;
        else         rem  <= rem & (rem - NUM_SRCS'(1));
      end
      if ((state != IDLE) && ev) begin
        if (done) begin
          if (pnd_v) pnd <= in_s;
        end else if (!pnd_v) begin
          pnd   <= in_s;
          pnd_v <= 1'b1;
        end else if (ovf != 16'hFFFF) begin
          ovf <= ovf + 16'd1;
        end
      end else if (done && pnd_v) begin
        pnd_v <= 1'b0;
      end
    end
  end

endmodule
